key_debounce_repeat: RTL and testbench

//  Conditions one raw active-low push button (DE1-SoC KEY) for the counter/multiplier datapath.

---
 rtl/key_debounce_repeat.sv | 184 ++++++++++++++++++
 tb/tb_key_debounce_repeat.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
// Conditions one raw active-low push button. The button is synchronized, debounced and
// edge-detected. The block emits a one-cycle press strobe on an accepted press, more press
// strobes while the key is held (auto-repeat), and a one-cycle strobe on an accepted release.
// All outputs are registered and follow the next state of the FSM, so they change on the
// same edge as the state transition.

module key_debounce_repeat #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_active
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  // Terminal counts are stored as "value - 1" because the timer starts at 0 on entry.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TMR_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMR_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TMR_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   key_s;
  state_t                 state_r;
  state_t                 state_nx;
  logic [CNT_W-1:0]       timer_r;
  logic [CNT_W-1:0]       timer_nx;
  logic                   press_nx;
  logic                   release_nx;
  logic                   tmr_clr_s;
  logic                   key_level_nx;
  logic                   repeat_active_nx;

  // Synchronizer chain; reset loads the released level so that reset itself never looks like a key event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_n};
    end
  end

  assign key_s = sync_r[SYNC_STAGES-1];

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= TMR_ZERO;
    end else begin
      state_r <= state_nx;
      timer_r <= timer_nx;
    end
  end

  // Next-state logic; a key_s change is checked before any terminal count so bounces always win.
  always_comb begin
    state_nx   = state_r;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    tmr_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!key_s) begin
          state_nx = PRESS_WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_nx = IDLE;
        end else if (timer_r == DEB_LAST) begin
          state_nx = HELD;
          press_nx = 1'b1;
        end else begin
          state_nx = PRESS_WAIT;
        end
      end
      HELD: begin
        if (key_s) begin
          state_nx = RELEASE_WAIT;
        end else if (!repeat_en) begin
          tmr_clr_s = 1'b1;          // repeat delay does not run while repeat is disabled
        end else if (timer_r == DELAY_LAST) begin
          state_nx = REPEAT;
          press_nx = 1'b1;
        end else begin
          state_nx = HELD;
        end
      end
      REPEAT: begin
        if (key_s) begin
          state_nx = RELEASE_WAIT;
        end else if (!repeat_en) begin
          state_nx = HELD;
        end else if (timer_r == PER_LAST) begin
          press_nx  = 1'b1;
          tmr_clr_s = 1'b1;
        end else begin
          state_nx = REPEAT;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_nx = HELD;           // glitch: back to held, repeat delay restarts
        end else if (timer_r == DEB_LAST) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end else begin
          state_nx = RELEASE_WAIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Timer: cleared on every state change or explicit clear, otherwise counts up and saturates.
  always_comb begin
    timer_nx = timer_r;
    if ((state_nx != state_r) || tmr_clr_s) begin
      timer_nx = TMR_ZERO;
    end else if (timer_r != TMR_MAX) begin
      timer_nx = timer_r + TMR_ONE;
    end else begin
      timer_nx = timer_r;
    end
  end

  // Level outputs are decoded from the next state so they line up with the strobes.
  always_comb begin
    key_level_nx     = 1'b0;
    repeat_active_nx = 1'b0;
    case (state_nx)
      HELD:         key_level_nx = 1'b1;
      REPEAT: begin
        key_level_nx     = 1'b1;
        repeat_active_nx = 1'b1;
      end
      RELEASE_WAIT: key_level_nx = 1'b1;
      default: begin
        key_level_nx     = 1'b0;
        repeat_active_nx = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears every output without producing a release strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      key_level     <= key_level_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      repeat_active <= repeat_active_nx;
    end
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed testbench for key_debounce_repeat with small timing parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
// Inputs change and outputs are sampled 1 ns after the rising edge.

module tb_key_debounce_repeat;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic repeat_en;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_active;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;
  logic both_seen = 1'b0;
  int p0;
  int r0;

  key_debounce_repeat #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .repeat_en(repeat_en),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  // Pulse counters and exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse === 1'b1) press_cnt = press_cnt + 1;
    if (release_pulse === 1'b1) rel_cnt = rel_cnt + 1;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) both_seen = 1'b1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    // 1: reset held with key pressed -> all outputs 0
    reset = 1'b1; key_n = 1'b0; repeat_en = 1'b0;
    step(3);
    check("rst_level",   key_level,     1'b0);
    check("rst_press",   press_pulse,   1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_repeat",  repeat_active, 1'b0);

    // 2: reset drops with key held; next edge is E0, press after edge E0+10
    reset = 1'b0;
    step(10);
    check("deb_early_press", press_pulse, 1'b0);
    check("deb_early_level", key_level,   1'b0);
    step(1);
    check("press_pulse", press_pulse,   1'b1);
    check("press_level", key_level,     1'b1);
    check("press_norep", repeat_active, 1'b0);
    step(1);
    check("press_one_cycle", press_pulse, 1'b0);
    p0 = press_cnt;
    step(100);
    check("norep_count", press_cnt - p0, 0);
    check("norep_level", key_level,      1'b1);

    // 4: enable repeat while held; first repeat 20 cycles later, then every 5
    repeat_en = 1'b1;
    step(19);
    check("rep_early_press",  press_pulse,   1'b0);
    check("rep_early_active", repeat_active, 1'b0);
    step(1);
    check("rep_first_press",  press_pulse,   1'b1);
    check("rep_first_active", repeat_active, 1'b1);
    step(4);
    check("rep_gap", press_pulse, 1'b0);
    step(1);
    check("rep_second", press_pulse, 1'b1);
    step(5);
    check("rep_third", press_pulse, 1'b1);
    repeat_en = 1'b0;
    step(1);
    check("rep_off_active", repeat_active, 1'b0);
    check("rep_off_level",  key_level,     1'b1);

    // 5: short release glitch while held -> nothing happens
    p0 = press_cnt; r0 = rel_cnt;
    key_n = 1'b1;
    step(3);
    key_n = 1'b0;
    step(3);
    check("glitch_level_mid", key_level, 1'b1);
    step(20);
    check("glitch_no_release", rel_cnt - r0,   0);
    check("glitch_no_press",   press_cnt - p0, 0);
    check("glitch_level",      key_level,      1'b1);

    // 5: final release from E1 -> release strobe after edge E1+10
    key_n = 1'b1;
    step(10);
    check("rel_early", release_pulse, 1'b0);
    check("rel_early_level", key_level, 1'b1);
    step(1);
    check("rel_pulse", release_pulse, 1'b1);
    check("rel_level", key_level,     1'b0);
    check("rel_no_press", press_pulse, 1'b0);
    step(1);
    check("rel_one_cycle", release_pulse, 1'b0);

    // 3: key low for only 5 cycles -> rejected as bounce
    p0 = press_cnt;
    key_n = 1'b0;
    step(5);
    key_n = 1'b1;
    step(20);
    check("bounce_no_press", press_cnt - p0, 0);
    check("bounce_level",    key_level,      1'b0);

    // 6: reset while in REPEAT
    key_n = 1'b0; repeat_en = 1'b1;
    step(11);
    check("r6_press", press_pulse, 1'b1);
    step(20);
    check("r6_repeat_press",  press_pulse,   1'b1);
    check("r6_repeat_active", repeat_active, 1'b1);
    r0 = rel_cnt;
    reset = 1'b1;
    step(1);
    check("r6_rst_level",   key_level,     1'b0);
    check("r6_rst_repeat",  repeat_active, 1'b0);
    check("r6_rst_press",   press_pulse,   1'b0);
    check("r6_rst_release", release_pulse, 1'b0);
    reset = 1'b0;
    p0 = press_cnt;
    step(10);
    check("r6_no_early_press", press_cnt - p0, 0);
    check("r6_no_release",     rel_cnt - r0,   0);
    check("r6_level_low",      key_level,      1'b0);
    step(1);
    check("r6_press_again", press_pulse, 1'b1);
    check("r6_level_again", key_level,   1'b1);

    check("never_both_pulses", both_seen, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
